// File: rtl/result_serial_tx_if.sv
// rtl/result_serial_tx_if.sv - result capture input and serial valid/ready output bundle
interface result_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] result_in;
  logic              result_valid;
  logic              tx_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_last;

  modport master (
    output result_in, result_valid, tx_ready,
    input  tx_bit, tx_valid, tx_last
  );

  modport slave (
    input  result_in, result_valid, tx_ready,
    output tx_bit, tx_valid, tx_last
  );
endinterface

// File: rtl/result_serial_tx.sv
// rtl/result_serial_tx.sv - result FIFO feeding an MSB-first serial framer with inter-frame gap
// Optional even-parity trailer bit: RESULT_SERIAL_TX_PARITY_EN
module result_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  result_serial_tx_if.slave      bus,
  input  logic                   overflow_clr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
`ifdef RESULT_SERIAL_TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int BC_W = $clog2(FRAME_W + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0] PEN_IDX  = BC_W'(FRAME_W - 2);
  localparam logic [3:0]      GAP_LAST = 4'(GAP_CYC - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FRAME_W-1:0]  shreg;
  logic [BC_W-1:0]     bit_cnt;
  logic [3:0]          gap_cnt;
  logic                tx_valid_r;
  logic                tx_last_r;
  logic                push;
  logic                drop;
  logic                pop;
  logic [DATA_W-1:0]   head;
  logic [FRAME_W-1:0]  head_frame;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign push = bus.result_valid && (fifo_count != FULL_CNT);
  assign drop = bus.result_valid && (fifo_count == FULL_CNT);
  assign pop  = (state == S_LOAD);
  assign head = mem[rd_ptr];

`ifdef RESULT_SERIAL_TX_PARITY_EN
  assign head_frame = {head, ^head};
`else
  assign head_frame = head;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_count != '0) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg      <= head_frame;
          bit_cnt    <= '0;
          tx_valid_r <= 1'b1;
          tx_last_r  <= 1'b0;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bus.tx_ready) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_IDX) begin
              tx_valid_r <= 1'b0;
              tx_last_r  <= 1'b0;
              gap_cnt    <= '0;
              if (GAP_CYC > 0) begin
                state <= S_GAP;
              end else if (fifo_count != '0) begin
                state <= S_LOAD;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              tx_last_r <= (bit_cnt == PEN_IDX);
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_bit   = shreg[FRAME_W-1];
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_last  = tx_last_r;
  assign busy         = (state != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_result_serial_tx.sv
// tb/tb_result_serial_tx.sv - scoreboard bench for result_serial_tx
module tb_result_serial_tx;

`ifdef RESULT_SERIAL_TX_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       overflow_clr = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  result_serial_tx_if #(.DATA_W(8)) bus ();

  result_serial_tx #(.DATA_W(8), .DEPTH(4), .GAP_CYC(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .overflow_clr (overflow_clr),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [7:0] w);
`ifdef RESULT_SERIAL_TX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] w);
    bus.result_valid = 1'b1;
    bus.result_in    = w;
    tick();
    bus.result_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  // Monitor: assembles accepted bits into frames and compares against the queue.
  initial begin
    logic [FW-1:0] frame = '0;
    int nbits = 0;
    logic hold_pend = 1'b0;
    logic held_bit = 1'b0;
    logic held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nbits = 0;
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", bus.tx_valid, 1);
          chk("hold_bit", bus.tx_bit, held_bit);
          chk("hold_last", bus.tx_last, held_last);
        end
        hold_pend = bus.tx_valid && !bus.tx_ready;
        held_bit  = bus.tx_bit;
        held_last = bus.tx_last;
        if (bus.tx_valid && bus.tx_ready) begin
          frame = {frame[FW-2:0], bus.tx_bit};
          nbits++;
          chk("tx_last", bus.tx_last, (nbits == FW) ? 1 : 0);
          if (nbits == FW) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_frame: got %0h expected none", frame);
            end else begin
              chk("frame", frame, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.result_in    = '0;
    bus.result_valid = 1'b0;
    bus.tx_ready     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_last", bus.tx_last, 0);
    chk("rst_tx_bit", bus.tx_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);

    // 1: single word, latency N+3, frame length, busy release
    exp_q.push_back(frame_of(8'hA5));
    pulse(8'hA5);
    chk("lat_n1", bus.tx_valid, 0);
    chk("count_after_push", fifo_count, 1);
    tick();
    chk("lat_n2", bus.tx_valid, 0);
    tick();
    chk("lat_n3", bus.tx_valid, 1);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus.tx_valid) break;
      n++;
    end
    chk("frame_len", n, FW);
    chk("gap_busy", busy, 1);
    tick();
    chk("busy_drop", busy, 0);

    // 2: backpressure pattern 1,0,0,1,...
    exp_q.push_back(frame_of(8'h3C));
    pulse(8'h3C);
    for (int i = 0; i < 60; i++) begin
      bus.tx_ready = (i % 3 == 0) || (i % 3 == 2) ? ((i % 3) == 0) : 1'b0;
      bus.tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    bus.tx_ready = 1'b1;
    wait_idle("bp_idle");

    // 3: overflow with stalled consumer
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(frame_of(8'(i)));
    for (int i = 1; i <= 6; i++) pulse(8'(i));
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    bus.tx_ready = 1'b1;
    wait_idle("ovf_idle");
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // 4: back-to-back frames; gap = GAP cycles + IDLE + LOAD
    exp_q.push_back(frame_of(8'hFF));
    exp_q.push_back(frame_of(8'h00));
    pulse(8'hFF);
    pulse(8'h00);
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_valid && bus.tx_last) break;
      tick();
    end
    chk("b2b_last_seen", bus.tx_last, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_valid) break;
      n++;
    end
    chk("b2b_gap", n, GAP + 2);
    wait_idle("b2b_idle");

    // 5: reset in the middle of a frame with queued words
    bus.tx_ready = 1'b0;
    pulse(8'hA5);
    pulse(8'h11);
    pulse(8'h22);
    pulse(8'h33);
    pulse(8'h44);
    pulse(8'h55);
    chk("pre_rst_overflow", overflow, 1);
    chk("pre_rst_count", fifo_count, 4);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", bus.tx_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.tx_valid) n++;
    end
    chk("mid_rst_silent", n, 0);

`ifdef RESULT_SERIAL_TX_PARITY_EN
    // 6: parity frames
    exp_q.push_back(9'h00F);
    exp_q.push_back(9'h006);
    pulse(8'h07);
    pulse(8'h03);
    wait_idle("par_idle");
`endif

    repeat (5) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
